// File: rtl/maxmin_frame_arbiter_pkg.sv
// Shared types and constants for the max/min frame arbiter slice.
package maxmin_arb_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, STREAM, WAIT, RESULT} arb_state_e;

  localparam int DONE_TIMEOUT  = 4;
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_FRAME_LEN = 15;
endpackage

// File: rtl/maxmin_frame_arbiter_if.sv
// Requester, core and result signals of the max/min arbiter.
interface maxmin_frame_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0][DW-1:0] req_num;
  logic [N_REQ-1:0]         gnt;
  logic                     core_valid;
  logic [DW-1:0]            core_num;
  logic [DW-1:0]            core_max;
  logic [DW-1:0]            core_min;
  logic                     core_done;
  logic                     res_valid;
  logic [IDW-1:0]           res_id;
  logic [DW-1:0]            res_max;
  logic [DW-1:0]            res_min;
  logic                     err;
  logic                     busy;

  // arbiter side
  modport slave (
    input  req, req_valid, req_num, core_max, core_min, core_done,
    output gnt, core_valid, core_num, res_valid, res_id, res_max, res_min, err, busy
  );

  // clients + core side
  modport master (
    output req, req_valid, req_num, core_max, core_min, core_done,
    input  gnt, core_valid, core_num, res_valid, res_id, res_max, res_min, err, busy
  );
endinterface

// File: rtl/maxmin_frame_arbiter_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping around.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] oh,
  output logic [IDW-1:0]   id,
  output logic             any
);
  always_comb begin
    int k;
    oh  = '0;
    id  = '0;
    any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!any && req[k]) begin
        any   = 1'b1;
        oh[k] = 1'b1;
        id    = IDW'(k);
      end
    end
  end
endmodule

// File: rtl/maxmin_frame_arbiter.sv
// Time-shares one streaming max/min core across N_REQ requesters, one frame per grant.
module maxmin_frame_arbiter
  import maxmin_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int DW        = DEF_DW,
  parameter int IDW       = $clog2(N_REQ)
) (
  input logic                  clk,
  input logic                  rst_n,
  maxmin_frame_arbiter_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TMO = TW'(DONE_TIMEOUT - 1);

  arb_state_e       state;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   w;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    beat_cnt;
  logic [TW-1:0]    wait_cnt;
  logic             core_valid;
  logic [DW-1:0]    core_num;
  logic             res_valid;
  logic [IDW-1:0]   res_id;
  logic [DW-1:0]    res_max;
  logic [DW-1:0]    res_min;
  logic             err;

  logic [N_REQ-1:0] pick_oh;
  logic [IDW-1:0]   pick_id;
  logic             pick_any;
  logic [IDW-1:0]   nxt_ptr;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req (bus.req),
    .ptr (rr_ptr),
    .oh  (pick_oh),
    .id  (pick_id),
    .any (pick_any)
  );

  assign nxt_ptr = (pick_id == IDW'(N_REQ - 1)) ? '0 : pick_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      w          <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      wait_cnt   <= '0;
      core_valid <= 1'b0;
      core_num   <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_max    <= '0;
      res_min    <= '1;
      err        <= 1'b0;
    end else begin
      err       <= 1'b0;
      res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          core_valid <= 1'b0;
          beat_cnt   <= '0;
          if (pick_any) begin
            gnt    <= pick_oh;
            w      <= pick_id;
            rr_ptr <= nxt_ptr;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (bus.req_valid[w]) begin
            core_valid <= 1'b1;
            core_num   <= bus.req_num[w];
            beat_cnt   <= CW'(1);
            state      <= STREAM;
          end else if (!bus.req[w]) begin
            // withdrawn before any beat reached the core: nothing to abort
            gnt   <= '0;
            state <= IDLE;
          end
        end
        STREAM: begin
          if (bus.req_valid[w]) begin
            core_valid <= 1'b1;
            core_num   <= bus.req_num[w];
            beat_cnt   <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_CNT) begin
              gnt      <= '0;
              wait_cnt <= '0;
              state    <= WAIT;
            end
          end else begin
            // a gap breaks the core's contiguous-frame count, so drop the frame
            err        <= 1'b1;
            gnt        <= '0;
            core_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        WAIT: begin
          core_valid <= 1'b0;
          if (bus.core_done) begin
            res_max   <= bus.core_max;
            res_min   <= bus.core_min;
            res_id    <= w;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else if (wait_cnt == LAST_TMO) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESULT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt;
  assign bus.core_valid = core_valid;
  assign bus.core_num   = core_num;
  assign bus.res_valid  = res_valid;
  assign bus.res_id     = res_id;
  assign bus.res_max    = res_max;
  assign bus.res_min    = res_min;
  assign bus.err        = err;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_maxmin_frame_arbiter.sv
// Directed bench for maxmin_frame_arbiter with a behavioural max/min core stand-in.
module tb_maxmin_frame_arbiter;
  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int FLEN  = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maxmin_frame_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  maxmin_frame_arbiter #(.N_REQ(N_REQ), .FRAME_LEN(FLEN), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_res = 0;
  int unsigned d [FLEN] = '{10, 200, 3, 50, 60, 70, 80, 90, 100, 110, 120, 130, 140, 150, 77};

  // core stand-in: done one cycle after the FLEN-th contiguous beat
  logic [4:0]    cm_cnt;
  logic [DW-1:0] run_max, run_min, nmax, nmin;
  always_comb begin
    nmax = (cm_cnt == 0 || bus.core_num > run_max) ? bus.core_num : run_max;
    nmin = (cm_cnt == 0 || bus.core_num < run_min) ? bus.core_num : run_min;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_cnt <= '0; run_max <= '0; run_min <= '0;
      bus.core_done <= 1'b0; bus.core_max <= '0; bus.core_min <= '0;
    end else begin
      bus.core_done <= 1'b0;
      if (bus.core_valid) begin
        run_max <= nmax;
        run_min <= nmin;
        if (cm_cnt == 5'(FLEN - 1)) begin
          cm_cnt        <= '0;
          bus.core_done <= 1'b1;
          bus.core_max  <= nmax;
          bus.core_min  <= nmin;
        end else cm_cnt <= cm_cnt + 1'b1;
      end else cm_cnt <= '0;
    end
  end

  always @(negedge clk) if (bus.res_valid) n_res++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input logic [N_REQ-1:0] exp);
    for (int i = 0; i < 8 && bus.gnt == '0; i++) tick();
    chk("gnt", bus.gnt, exp);
  endtask

  task automatic send_frame(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid[id] = 1'b1;
      bus.req_num[id]   = 8'(d[i]);
      tick();
      chk("fwd_valid", bus.core_valid, 1);
      chk("fwd_num", bus.core_num, d[i]);
    end
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_result(input int id);
    for (int i = 0; i < 10 && !bus.res_valid; i++) tick();
    chk("res_valid", bus.res_valid, 1);
    chk("res_id", bus.res_id, id);
    chk("res_max", bus.res_max, 200);
    chk("res_min", bus.res_min, 3);
    chk("res_gnt_clear", bus.gnt, 0);
    chk("res_err", bus.err, 0);
    tick();
    chk("res_pulse", bus.res_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_core_valid"}, bus.core_valid, 0);
    chk({tag, "_core_num"}, bus.core_num, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_id"}, bus.res_id, 0);
    chk({tag, "_res_max"}, bus.res_max, 0);
    chk({tag, "_res_min"}, bus.res_min, 255);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap;
    bus.req = '0; bus.req_valid = '0; bus.req_num = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset_vals("rst");

    // single requester 2
    bus.req = 4'b0100;
    tick();
    chk("single_gnt", bus.gnt, 4'b0100);
    chk("single_busy", bus.busy, 1);
    send_frame(2, FLEN);
    bus.req = '0;
    wait_result(2);

    // withdraw: grant 3, drop before any beat
    bus.req = 4'b1000;
    wait_grant(4'b1000);
    bus.req = '0;
    tick();
    chk("wd_gnt", bus.gnt, 0);
    chk("wd_err", bus.err, 0);
    chk("wd_busy", bus.busy, 0);

    // fairness: pointer wrapped to 0, all held
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(4'b0001 << (k % 4));
      send_frame(k % 4, FLEN);
      if (k == 4) bus.req = '0;
      wait_result(k % 4);
    end

    // abort: requester 1, gap after beat 7
    snap = n_res;
    bus.req = 4'b0010;
    wait_grant(4'b0010);
    send_frame(1, 7);
    tick();
    chk("abort_err", bus.err, 1);
    chk("abort_gnt", bus.gnt, 0);
    chk("abort_core_valid", bus.core_valid, 0);
    chk("abort_busy", bus.busy, 0);
    bus.req = 4'b0100;
    tick();
    chk("abort_err_pulse", bus.err, 0);
    chk("abort_next_gnt", bus.gnt, 4'b0100);
    send_frame(2, FLEN);
    bus.req = '0;
    wait_result(2);
    chk("abort_no_result", n_res - snap, 1);

    // isolation: requester 1 floods 255 while 0 owns the core
    bus.req_valid[1] = 1'b1;
    bus.req_num[1]   = 8'hFF;
    bus.req = 4'b0001;
    wait_grant(4'b0001);
    send_frame(0, FLEN);
    bus.req = '0;
    wait_result(0);
    bus.req_valid[1] = 1'b0;

    // async reset at beat 9 of requester 1
    bus.req = 4'b0010;
    wait_grant(4'b0010);
    send_frame(1, 9);
    rst_n = 1'b0;
    bus.req = '0;
    #1;
    chk_reset_vals("arst");
    tick();
    rst_n = 1'b1;
    bus.req = 4'b0111;
    wait_grant(4'b0001);
    bus.req = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/maxmin_frame_arbiter.md
Name: maxmin_frame_arbiter

Overview:
- Round-robin arbiter that shares one streaming max/min statistics core among N_REQ requesters, one frame at a time.
- Grants one requester and forwards its FRAME_LEN-beat frame to the core.
- Captures the core's max/min result and returns it tagged with the requester id.
- Sits between the client blocks and the single max/min core instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_LEN, 15, beats per frame; must equal the core's frame length.
- DW, 8, data width.
- IDW, $clog2(N_REQ), requester id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester frame request, level.
- req_valid  in  N_REQ  per-requester data beat valid.
- req_num  in  N_REQ*DW  per-requester data; requester i owns bits [i*DW +: DW].
- gnt  out  N_REQ  one-hot grant, registered.
- core_valid  out  1  beat valid to the core, registered.
- core_num  out  DW  beat data to the core, registered.
- core_max  in  DW  core result, maximum.
- core_min  in  DW  core result, minimum.
- core_done  in  1  core result valid; high 1 cycle after the core sees its FRAME_LEN-th contiguous beat.
- res_valid  out  1  result pulse, 1 cycle.
- res_id  out  IDW  requester id that owns the result.
- res_max  out  DW  captured maximum.
- res_min  out  DW  captured minimum.
- err  out  1  1-cycle pulse on frame abort.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: gnt=0, core_valid=0, core_num=0, res_valid=0, res_id=0, res_max=0, res_min=255 (all ones), err=0, busy=0, state=IDLE, rr_ptr=0, beat_cnt=0.
- States: IDLE, GRANT, STREAM, WAIT, RESULT.
- IDLE:
  - If any req is high, the winner is the first set bit searching upward from rr_ptr with wrap-around.
  - Next cycle: gnt[winner]=1, state=GRANT, rr_ptr=winner+1 mod N_REQ.
  - The pointer advances even if the frame later aborts.
- GRANT:
  - req_valid[w]=1: forward the beat, beat_cnt=1, go to STREAM.
  - req[w] drops before the first beat: gnt cleared, go to IDLE, no err.
- STREAM:
  - Each cycle with req_valid[w]=1 forwards one beat and increments beat_cnt.
  - When the FRAME_LEN-th beat is forwarded: gnt cleared next cycle, go to WAIT.
  - Gap (req_valid[w]=0) before FRAME_LEN beats: abort. Pulse err, clear gnt, core_valid=0 next cycle, go to IDLE, no result.
- Forwarding:
  - core_valid and core_num are registered copies of the granted requester's beat (1-cycle latency).
  - Beats from non-granted requesters are ignored entirely.
  - core_num holds its last value when core_valid=0.
- WAIT:
  - On core_done=1: capture core_max/core_min into res_max/res_min, set res_id=w, go to RESULT.
  - If core_done is not seen within 4 cycles: pulse err, go to IDLE.
- RESULT: res_valid=1 for exactly one cycle, then IDLE. res_* hold their values until the next capture.
- Latency: req high in IDLE at cycle t gives gnt at t+1. The first beat at t+1 reaches core_valid at t+2.
- Requests raised while busy wait; a level req stays pending until served.
- A new grant is issued no earlier than the cycle after res_valid or err.
- Async reset at any point: immediate return to reset values; any in-flight frame is lost with no err.
- beat_cnt width is $clog2(FRAME_LEN+1); no wrap, because the count stops at FRAME_LEN.

Decomposition:
- Package maxmin_arb_pkg holds:
  - state enum arb_state_e {IDLE, GRANT, STREAM, WAIT, RESULT};
  - localparam DONE_TIMEOUT=4;
  - default DW/FRAME_LEN constants.
- One sub-module: rr_pick. Combinational; takes a request vector and a pointer, returns a one-hot winner and its id.
- The core stays outside this block, connected at the top level.

Test Plan:
- Single requester: req[2]=1, 15 contiguous beats 10,200,3,…,77 → core receives the same 15 beats 1 cycle delayed; core_done returns max=200/min=3 → res_valid=1, res_id=2, res_max=200, res_min=3.
- Fairness: req=4'b1111 held, every frame complete → grant order 0,1,2,3,0; each res_id matches its grant.
- Abort: requester 1 granted, gap after beat 7 → err pulse, gnt=0, core_valid low, no res_valid; next grant goes to requester 2 when req[2]=1.
- Withdraw: req[3] drops in GRANT before any beat → gnt=0, no err, back to IDLE; rr_ptr=0.
- Isolation: requester 0 granted while requester 1 drives req_valid=1, req_num=255 throughout → only requester 0 data appears on core_num; result unaffected.
- Reset mid-STREAM (rst_n low at beat 9) → all outputs at reset values immediately; after release, req[0] is granted first.
